// File: rtl/urisc_mem_pkg.sv
// Shared definitions for the URISC data-memory initiator and the core decoder.
//   op_t / OP_*  : request opcode encoding (READ, WRITE, SUB, reserved)
//   state_t      : initiator sequencing states
package urisc_mem_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_READ  = 2'b00;
  localparam op_t OP_WRITE = 2'b01;
  localparam op_t OP_SUB   = 2'b10;
  localparam op_t OP_RSVD  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_A,
    ST_RD_B,
    ST_WR,
    ST_RESP
  } state_t;

endpackage

// File: rtl/mem_initiator_if.sv
// Request/response handshake plus memory bus of the data-memory initiator.
//   req_*  : one request per valid/ready handshake (op, addr_a, addr_b, wdata)
//   rsp_*  : one response per request, held until rsp_valid & rsp_ready
//   mem_*  : registered CS/Read/Write/Addr/Data strobes, combinational read data
// modport master : the initiator (owns the memory bus, answers requests)
// modport slave  : the environment (core issuing requests + memory responder)
interface mem_initiator_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 9
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [AW-1:0]    req_addr_a;
  logic [AW-1:0]    req_addr_b;
  logic [WIDTH-1:0] req_wdata;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_rdata;
  logic             rsp_leq;
  logic             mem_cs;
  logic             mem_read;
  logic             mem_write;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;

  modport master (
    input  req_valid, req_op, req_addr_a, req_addr_b, req_wdata, rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_leq,
           mem_cs, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport slave (
    output req_valid, req_op, req_addr_a, req_addr_b, req_wdata, rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_leq,
           mem_cs, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_initiator.sv
// Bus initiator for the single-port data memory. Accepts one request at a time,
// sequences the memory strobes and returns one response.
//   READ  : IDLE -> RD_A -> RESP
//   WRITE : IDLE -> WR -> RESP
//   SUB   : IDLE -> RD_A -> RD_B -> WR -> RESP, mem[b] <= mem[b] - mem[a],
//           rsp_leq = (result as signed) <= 0
//   RSVD  : IDLE -> RESP, no strobes, zero response
// Ports: clk, reset (sync, active-high), bus (mem_initiator_if.master).
// Memory strobes are registered: they are computed from the next state so that
// they are high exactly during RD_A, RD_B and WR.
module mem_initiator
  import urisc_mem_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 512
) (
  input logic             clk,
  input logic             reset,
  mem_initiator_if.master bus
);
  localparam int AW = $clog2(DEPTH);

  function automatic logic is_leq(input logic signed [WIDTH-1:0] x);
    return x[WIDTH-1] | (x == '0);
  endfunction

  state_t                  state_q, state_d;
  op_t                     op_q, op_d;
  logic [AW-1:0]           addr_a_q, addr_a_d;
  logic [AW-1:0]           addr_b_q, addr_b_d;
  logic signed [WIDTH-1:0] opa_q, opa_d;
  logic signed [WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_leq_q, rsp_leq_d;
  logic                    mem_cs_q, mem_cs_d;
  logic                    mem_read_q, mem_read_d;
  logic                    mem_write_q, mem_write_d;
  logic [AW-1:0]           mem_addr_q, mem_addr_d;
  logic signed [WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  logic                    accept;
  logic signed [WIDTH-1:0] sub_res;

  assign accept  = bus.req_valid & bus.req_ready;
  // Only meaningful in RD_B, where mem_rdata carries mem[b].
  assign sub_res = $signed(bus.mem_rdata) - opa_q;

  assign bus.req_ready = (state_q == ST_IDLE) & ~reset;
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_leq   = rsp_leq_q;
  assign bus.mem_cs    = mem_cs_q;
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_READ;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      opa_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_leq_q   <= 1'b0;
      mem_cs_q    <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_a_q    <= addr_a_d;
      addr_b_q    <= addr_b_d;
      opa_q       <= opa_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_leq_q   <= rsp_leq_d;
      mem_cs_q    <= mem_cs_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          unique case (bus.req_op)
            OP_READ:  state_d = ST_RD_A;
            OP_WRITE: state_d = ST_WR;
            OP_SUB:   state_d = ST_RD_A;
            default:  state_d = ST_RESP;
          endcase
        end
      end
      ST_RD_A: state_d = (op_q == OP_SUB) ? ST_RD_B : ST_RESP;
      ST_RD_B: state_d = ST_WR;
      ST_WR:   state_d = ST_RESP;
      ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath logic
  always_comb begin
    op_d        = op_q;
    addr_a_d    = addr_a_q;
    addr_b_d    = addr_b_q;
    opa_d       = opa_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_leq_d   = rsp_leq_q;

    if (state_q == ST_IDLE && accept) begin
      op_d        = bus.req_op;
      addr_a_d    = bus.req_addr_a;
      addr_b_d    = bus.req_addr_b;
      rsp_rdata_d = '0;
      rsp_leq_d   = 1'b0;
    end
    if (state_q == ST_RD_A) begin
      opa_d = $signed(bus.mem_rdata);
      if (op_q == OP_READ) rsp_rdata_d = $signed(bus.mem_rdata);
    end
    if (state_q == ST_RD_B) begin
      rsp_rdata_d = sub_res;
      rsp_leq_d   = is_leq(sub_res);
    end

    // Strobes follow the state being entered; IDLE-sourced values come straight
    // from the request because the capture registers load on the same edge.
    mem_cs_d    = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    unique case (state_d)
      ST_RD_A: begin
        mem_cs_d   = 1'b1;
        mem_read_d = 1'b1;
        mem_addr_d = bus.req_addr_a;
      end
      ST_RD_B: begin
        mem_cs_d   = 1'b1;
        mem_read_d = 1'b1;
        mem_addr_d = addr_b_q;
      end
      ST_WR: begin
        mem_cs_d    = 1'b1;
        mem_write_d = 1'b1;
        if (state_q == ST_IDLE) begin
          mem_addr_d  = bus.req_addr_a;
          mem_wdata_d = $signed(bus.req_wdata);
        end else begin
          mem_addr_d  = addr_b_q;
          mem_wdata_d = sub_res;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_initiator.sv
module tb_mem_initiator;
  import urisc_mem_pkg::*;

  localparam int WIDTH = 16;
  localparam int DEPTH = 512;
  localparam int AW    = 9;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mem_initiator_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  mem_initiator #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responder: combinational read, write on the negedge inside WR.
  logic [WIDTH-1:0] mem [DEPTH];
  logic             pl_en;
  logic [AW-1:0]    pl_addr;
  logic [WIDTH-1:0] pl_data;
  logic [AW:0]      trace [256];
  int               tr_n;
  int               cs_cnt;
  int               both_cnt;

  assign bus.mem_rdata = (bus.mem_cs && bus.mem_read) ? mem[bus.mem_addr] : '0;

  initial begin
    tr_n = 0; cs_cnt = 0; both_cnt = 0;
  end

  always @(negedge clk) begin
    if (pl_en) mem[pl_addr] = pl_data;
    if (bus.mem_cs) cs_cnt = cs_cnt + 1;
    if (bus.mem_read && bus.mem_write) both_cnt = both_cnt + 1;
    if (bus.mem_cs && bus.mem_write) mem[bus.mem_addr] = bus.mem_wdata;
    if (bus.mem_cs && (bus.mem_read || bus.mem_write) && tr_n < 256) begin
      trace[tr_n] = {bus.mem_write, bus.mem_addr};
      tr_n = tr_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    pl_addr = a; pl_data = d; pl_en = 1'b1;
    @(negedge clk);
    #1;
    pl_en = 1'b0;
  endtask

  // Drive one request through the accept edge, then scribble the inputs so
  // that later changes would corrupt a design that failed to capture them.
  task automatic do_req(input op_t op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                        input logic [WIDTH-1:0] wd);
    bus.req_valid  = 1'b1;
    bus.req_op     = op;
    bus.req_addr_a = a;
    bus.req_addr_b = b;
    bus.req_wdata  = wd;
    step();
    bus.req_valid  = 1'b0;
    bus.req_op     = 2'($urandom_range(0, 3));
    bus.req_addr_a = AW'($urandom);
    bus.req_addr_b = AW'($urandom);
    bus.req_wdata  = WIDTH'($urandom);
  endtask

  task automatic release_rsp();
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    int t0;
    int c0;
    int bad;
    logic [WIDTH-1:0] held;
    checks = 0; errors = 0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_op = OP_READ; bus.req_addr_a = '0;
    bus.req_addr_b = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b0;

    // Reset state
    step(); step();
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_strobes", {bus.mem_cs, bus.mem_read, bus.mem_write}, 0);
    reset = 1'b0;
    #1;
    chk("idle_req_ready", bus.req_ready, 1);

    // WRITE 0x010 <= 0xBEEF
    do_req(OP_WRITE, 9'h010, 9'h000, 16'hBEEF);
    chk("wr_rsp_valid_early", bus.rsp_valid, 0);
    chk("wr_strobes", {bus.mem_cs, bus.mem_read, bus.mem_write}, 3'b101);
    chk("wr_addr", bus.mem_addr, 9'h010);
    chk("wr_wdata", bus.mem_wdata, 16'hBEEF);
    step();
    chk("wr_rsp_valid", bus.rsp_valid, 1);
    chk("wr_rsp_rdata", bus.rsp_rdata, 0);
    chk("wr_mem", mem[9'h010], 16'hBEEF);
    release_rsp();
    chk("wr_back_idle", bus.req_ready, 1);

    // READ 0x010, then hold rsp_ready low for 10 cycles
    do_req(OP_READ, 9'h010, 9'h000, 16'h0000);
    chk("rd_strobes", {bus.mem_cs, bus.mem_read, bus.mem_write}, 3'b110);
    chk("rd_addr", bus.mem_addr, 9'h010);
    step();
    chk("rd_rsp_valid", bus.rsp_valid, 1);
    chk("rd_rsp_rdata", bus.rsp_rdata, 16'hBEEF);
    chk("rd_rsp_leq", bus.rsp_leq, 0);
    held = bus.rsp_rdata;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== held || bus.req_ready !== 1'b0 ||
          bus.mem_cs !== 1'b0 || bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) bad++;
    end
    chk("rd_hold_stable", bad, 0);
    release_rsp();
    chk("rd_release_valid", bus.rsp_valid, 0);
    chk("rd_release_ready", bus.req_ready, 1);

    // SUB 3 from 5 -> 2
    preload(9'h020, 16'h0003);
    preload(9'h021, 16'h0005);
    t0 = tr_n;
    do_req(OP_SUB, 9'h020, 9'h021, 16'h0000);
    bad = 0;
    if (bus.rsp_valid !== 1'b0) bad++;
    step(); if (bus.rsp_valid !== 1'b0) bad++;
    step(); if (bus.rsp_valid !== 1'b0) bad++;
    chk("sub1_valid_early", bad, 0);
    step();
    chk("sub1_rsp_valid", bus.rsp_valid, 1);
    chk("sub1_rdata", bus.rsp_rdata, 16'h0002);
    chk("sub1_leq", bus.rsp_leq, 0);
    chk("sub1_mem", mem[9'h021], 16'h0002);
    chk("sub1_trace_len", tr_n - t0, 3);
    chk("sub1_trace0", trace[t0], {1'b0, 9'h020});
    chk("sub1_trace1", trace[t0+1], {1'b0, 9'h021});
    chk("sub1_trace2", trace[t0+2], {1'b1, 9'h021});
    release_rsp();

    // SUB 5 from 3 -> -2
    preload(9'h040, 16'h0005);
    preload(9'h041, 16'h0003);
    do_req(OP_SUB, 9'h040, 9'h041, 16'h0000);
    step(); step(); step();
    chk("sub2_rdata", bus.rsp_rdata, 16'hFFFE);
    chk("sub2_leq", bus.rsp_leq, 1);
    chk("sub2_mem", mem[9'h041], 16'hFFFE);
    release_rsp();

    // SUB with a == b -> 0
    preload(9'h030, 16'h1234);
    do_req(OP_SUB, 9'h030, 9'h030, 16'h0000);
    step(); step(); step();
    chk("sub3_rdata", bus.rsp_rdata, 16'h0000);
    chk("sub3_leq", bus.rsp_leq, 1);
    chk("sub3_mem", mem[9'h030], 16'h0000);
    release_rsp();

    // Reset during RD_B: no write happens
    preload(9'h050, 16'h0007);
    preload(9'h051, 16'h0009);
    do_req(OP_SUB, 9'h050, 9'h051, 16'h0000);
    step();
    chk("rstb_in_rd_b", {bus.mem_read, bus.mem_addr}, {1'b1, 9'h051});
    reset = 1'b1;
    step();
    chk("rstb_strobes", {bus.mem_cs, bus.mem_read, bus.mem_write}, 0);
    chk("rstb_rsp_valid", bus.rsp_valid, 0);
    reset = 1'b0;
    step(); step();
    chk("rstb_mem_kept", mem[9'h051], 16'h0009);
    chk("rstb_idle", bus.req_ready, 1);

    // Reset during WR: the write has already committed
    do_req(OP_SUB, 9'h050, 9'h051, 16'h0000);
    step(); step();
    chk("rstw_in_wr", bus.mem_write, 1);
    reset = 1'b1;
    step();
    chk("rstw_strobes", {bus.mem_cs, bus.mem_read, bus.mem_write}, 0);
    chk("rstw_rsp_valid", bus.rsp_valid, 0);
    chk("rstw_mem_written", mem[9'h051], 16'h0002);
    reset = 1'b0;
    step();

    // Reserved op: immediate zero response, no chip select
    c0 = cs_cnt;
    do_req(OP_RSVD, 9'h055, 9'h066, 16'hAAAA);
    chk("rsvd_rsp_valid", bus.rsp_valid, 1);
    chk("rsvd_rdata", bus.rsp_rdata, 0);
    chk("rsvd_leq", bus.rsp_leq, 0);
    step();
    release_rsp();
    chk("rsvd_no_cs", cs_cnt - c0, 0);
    chk("rsvd_back_idle", bus.req_ready, 1);

    chk("strobe_exclusive", both_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_initiator.md
Name: mem_initiator

Overview:
Bus initiator that drives the single-port data memory (CS/Read/Write/Addr/Data_in/Data_out responder) on behalf of the core. Accepts one request at a time over a valid/ready port and sequences the memory strobes. Supports plain READ and WRITE, plus the URISC read-modify-write SUB: mem[b] <= mem[b] - mem[a], with a <=0 flag for the branch decision. Returns one response per request over a valid/ready port.

Parameters:
WIDTH, 16, data word width; must match the memory WIDTH.
DEPTH, 512, memory depth in words; address width AW = $clog2(DEPTH) (derived localparam).

Ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  synchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  high only in IDLE with reset low.
req_op  in  2  00 READ, 01 WRITE, 10 SUB, 11 reserved.
req_addr_a  in  AW  READ/WRITE address; SUB subtrahend address.
req_addr_b  in  AW  SUB minuend and destination address.
req_wdata  in  WIDTH  WRITE data.
rsp_valid  out  1  response present; held until accepted.
rsp_ready  in  1  response consumer ready.
rsp_rdata  out  WIDTH  READ data, or SUB result; 0 for WRITE and reserved.
rsp_leq  out  1  SUB only: result as signed <= 0; 0 for other ops.
mem_cs  out  1  memory chip select, registered.
mem_read  out  1  memory read strobe, registered.
mem_write  out  1  memory write strobe, registered.
mem_addr  out  AW  memory address, registered.
mem_wdata  out  WIDTH  memory write data, registered.
mem_rdata  in  WIDTH  memory read data (combinational from memory; 0 when not selected).

Behaviour:
- States: IDLE, RD_A, RD_B, WR, RESP. Reset -> IDLE. All outputs 0 while in reset; req_ready 0 while reset is high.
- Request accepted at a posedge with req_valid & req_ready; op, addresses and wdata are captured there; later changes are ignored.
- READ: IDLE -> RD_A (cs=1, read=1, addr=a) -> RESP. mem_rdata is sampled into rsp_rdata at the posedge that leaves RD_A. rsp_valid rises 2 cycles after the accept edge.
- WRITE: IDLE -> WR (cs=1, write=1, addr=a, wdata) -> RESP. The memory commits on the negedge inside WR. rsp_valid rises 2 cycles after accept.
- SUB: IDLE -> RD_A (read a, capture opA) -> RD_B (read b, capture opB) -> WR (addr=b, wdata=opB-opA) -> RESP. rsp_valid rises 4 cycles after accept.
- SUB arithmetic: result = (opB - opA) mod 2^WIDTH. rsp_leq = result[WIDTH-1] | (result == 0).
- SUB with a == b: the two reads return the same value, so result = 0 is written and rsp_leq = 1.
- Reserved op 11: IDLE -> RESP directly, with no strobes, rsp_rdata = 0 and rsp_leq = 0.
- RESP: rsp_valid = 1 with stable data until rsp_valid & rsp_ready at a posedge, then -> IDLE. No new request is accepted in the same cycle. Peak rate is one READ/WRITE per 3 cycles.
- rsp_ready held low: the block stays in RESP indefinitely and the memory strobes stay 0.
- Strobe exclusivity: read and write are never high together. cs is high exactly in RD_A, RD_B and WR. All strobes are 0 in IDLE and RESP.
- Reset mid-operation: at the first posedge with reset high, state -> IDLE, strobes -> 0 and any pending response is dropped. A WR strobe already driven before that edge has committed at its negedge; no other partial effect occurs.

Decomposition:
- Shared package urisc_mem_pkg holds: the op encoding constants (OP_READ, OP_WRITE, OP_SUB, OP_RSVD) and the state enum typedef. The core decoder uses the same op constants.
- Implement flat. The subtract/leq datapath is small and needs no sub-module.

Test Plan:
- WRITE a=0x010, wdata=0xBEEF, then READ a=0x010 -> the READ response has rsp_rdata=0xBEEF. rsp_valid appears 2 cycles after each accept edge.
- Preload mem[0x020]=0x0003 and mem[0x021]=0x0005; SUB a=0x020, b=0x021 -> rsp_rdata=0x0002, rsp_leq=0, mem[0x021]=0x0002. Exactly 2 read cycles and 1 write cycle occur, in the order a, b, b.
- Preload mem[a]=0x0005 and mem[b]=0x0003; SUB -> rsp_rdata=0xFFFE and rsp_leq=1. Also SUB with a=b=0x030 holding 0x1234 -> mem[0x030]=0 and rsp_leq=1.
- Hold rsp_ready=0 for 10 cycles after a READ -> rsp_valid and rsp_rdata stay stable, req_ready=0 and all mem strobes are 0. Raise rsp_ready -> IDLE the next cycle.
- Assert reset during RD_B of a SUB -> the next edge gives IDLE with all strobes 0 and no rsp_valid, and mem[b] is unchanged. Assert reset during WR instead -> mem[b] is updated.
- Reserved op 11 -> rsp_valid the cycle after accept, rsp_rdata=0, and mem_cs never asserted.
